neuron_mac: RTL and testbench

Per-neuron multiply-accumulate stage that sits directly downstream of the neuron's weight memory. It drives the memory's read port (`ren`/`radd`) in lockstep with the incoming activation stream and multiplies each returned weight by the matching activation. After `numWeight` activations it adds the neuron bias and emits one saturated fixed-point weighted sum, which feeds the activation-function stage.

---
 rtl/nn_pkg.sv | 50 +++++
 rtl/neuron_mac_sat_acc.sv | 29 ++
 rtl/neuron_mac.sv | 118 +++++++++++
 tb/tb_neuron_mac.sv | 238 +++++++++++++++++++++++
 4 files changed

// File: rtl/nn_pkg.sv
// Shared types and saturating-arithmetic helpers for the neuron datapath.
// The helpers work on a wide carrier and clip to a caller-chosen width.
package nn_pkg;

    typedef enum logic [1:0] {
        ACCUM  = 2'd0,
        DRAIN1 = 2'd1,
        DRAIN2 = 2'd2,
        FINAL  = 2'd3
    } mac_state_t;

    localparam int SAT_MAX_W = 64;

    // Clip a one-bit-wider value to the signed range of a w-bit word (w <= SAT_MAX_W).
    function automatic logic signed [SAT_MAX_W-1:0] sat_clip(
        input logic signed [SAT_MAX_W:0] v,
        input int                        w
    );
        logic signed [SAT_MAX_W:0] one;
        logic signed [SAT_MAX_W:0] hi;
        logic signed [SAT_MAX_W:0] lo;
        one = {{SAT_MAX_W{1'b0}}, 1'b1};
        hi  = (one <<< (w - 1)) - one;
        lo  = -hi - one;
        if (v > hi) begin
            return hi[SAT_MAX_W-1:0];
        end else if (v < lo) begin
            return lo[SAT_MAX_W-1:0];
        end
        return v[SAT_MAX_W-1:0];
    endfunction

    function automatic logic signed [SAT_MAX_W-1:0] sat_add(
        input logic signed [SAT_MAX_W-1:0] a,
        input logic signed [SAT_MAX_W-1:0] b,
        input int                          w
    );
        logic signed [SAT_MAX_W:0] s;
        s = {a[SAT_MAX_W-1], a} + {b[SAT_MAX_W-1], b};
        return sat_clip(s, w);
    endfunction

    function automatic logic signed [SAT_MAX_W-1:0] sat_narrow(
        input logic signed [SAT_MAX_W-1:0] a,
        input int                          w
    );
        return sat_clip({a[SAT_MAX_W-1], a}, w);
    endfunction

endpackage

// File: rtl/neuron_mac_sat_acc.sv
// Saturating accumulator register: clear wins over enable.
module sat_acc
    import nn_pkg::*;
#(
    parameter int W = 32
)(
    input  logic                clk,
    input  logic                rst_n,
    input  logic                i_clr,
    input  logic                i_en,
    input  logic signed [W-1:0] i_add,
    output logic signed [W-1:0] o_acc
);

    logic signed [W-1:0] r_acc;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_acc <= '0;
        end else if (i_clr) begin
            r_acc <= '0;
        end else if (i_en) begin
            r_acc <= W'(sat_add(SAT_MAX_W'(r_acc), SAT_MAX_W'(i_add), W));
        end
    end

    assign o_acc = r_acc;

endmodule

// File: rtl/neuron_mac.sv
// Per-neuron MAC: reads weight k alongside activation k, accumulates the
// products, adds the bias and emits one saturated Q-format sum per vector.
module neuron_mac
    import nn_pkg::*;
#(
    parameter int numWeight    = 784,
    parameter int addressWidth = 10,
    parameter int dataWidth    = 16,
    parameter int fracBits     = 8
)(
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic [dataWidth-1:0]    in_data,
    input  logic                    in_valid,
    output logic                    in_ready,
    input  logic [dataWidth-1:0]    bias,
    output logic                    ren,
    output logic [addressWidth-1:0] radd,
    input  logic [dataWidth-1:0]    wout,
    output logic [dataWidth-1:0]    out_data,
    output logic                    out_valid,
    output mac_state_t              dbg_state
);

    // Handshake: a sample transfers in any cycle where in_valid && in_ready;
    // in_valid may drop between samples, and the output side has no ready.

    mac_state_t                     r_state;
    logic [addressWidth-1:0]        r_cnt;
    logic signed [dataWidth-1:0]    r_x_d;
    logic                           r_v_d;
    logic signed [2*dataWidth-1:0]  r_prod;
    logic                           r_v_p;

    logic                           w_accept;
    logic                           w_last;
    logic                           w_final;
    logic signed [2*dataWidth-1:0]  w_acc;
    logic signed [2*dataWidth-1:0]  w_bias_sh;
    logic signed [2*dataWidth-1:0]  w_t;
    logic signed [2*dataWidth-1:0]  w_t_sh;

    assign in_ready  = (r_state == ACCUM);
    assign w_accept  = in_valid && in_ready;
    assign w_last    = (r_cnt == addressWidth'(numWeight - 1));
    assign w_final   = (r_state == FINAL);
    assign ren       = w_accept;
    assign radd      = r_cnt;
    assign dbg_state = r_state;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ACCUM;
        end else begin
            case (r_state)
                ACCUM:   if (w_accept && w_last) r_state <= DRAIN1;
                DRAIN1:  r_state <= DRAIN2;
                DRAIN2:  r_state <= FINAL;
                FINAL:   r_state <= ACCUM;
                default: r_state <= ACCUM;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt <= '0;
        end else if (w_accept) begin
            r_cnt <= w_last ? '0 : r_cnt + 1'b1;
        end
    end

    // P1 lines the sample up with the weight the memory returns one cycle later.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_x_d  <= '0;
            r_v_d  <= 1'b0;
            r_prod <= '0;
            r_v_p  <= 1'b0;
        end else begin
            if (w_accept) begin
                r_x_d <= $signed(in_data);
            end
            r_v_d  <= w_accept;
            r_prod <= $signed(wout) * r_x_d;
            r_v_p  <= r_v_d;
        end
    end

    sat_acc #(
        .W(2*dataWidth)
    ) u_sat_acc (
        .clk   (clk),
        .rst_n (rst_n),
        .i_clr (w_final),
        .i_en  (r_v_p),
        .i_add (r_prod),
        .o_acc (w_acc)
    );

    // Bias is aligned to the product's 2*fracBits scale before the add.
    assign w_bias_sh = $signed({{dataWidth{bias[dataWidth-1]}}, bias}) <<< fracBits;
    assign w_t       = (2*dataWidth)'(sat_add(SAT_MAX_W'(w_acc), SAT_MAX_W'(w_bias_sh), 2*dataWidth));
    assign w_t_sh    = w_t >>> fracBits;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_data  <= '0;
            out_valid <= 1'b0;
        end else begin
            out_valid <= w_final;
            if (w_final) begin
                out_data <= dataWidth'(sat_narrow(SAT_MAX_W'(w_t_sh), dataWidth));
            end
        end
    end

endmodule

// File: tb/tb_neuron_mac.sv
// Self-checking bench for neuron_mac in Q8.8 with three weights per vector.
module tb_neuron_mac;
  import nn_pkg::*;

  localparam int NW = 3;
  localparam int AW = 2;
  localparam int DW = 16;
  localparam int FB = 8;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic [DW-1:0] in_data = '0;
  logic          in_valid = 1'b0;
  logic          in_ready;
  logic [DW-1:0] bias = '0;
  logic          ren;
  logic [AW-1:0] radd;
  logic [DW-1:0] wout = '0;
  logic [DW-1:0] out_data;
  logic          out_valid;
  mac_state_t    dbg_state;

  logic [DW-1:0] mem [4];
  logic [DW-1:0] exp_q[$];
  int n_checks = 0;
  int n_fail = 0;

  typedef struct {
    string            name;
    logic [2:0][15:0] w;
    logic [2:0][15:0] x;
    logic [15:0]      b;
    int               gap;
    logic [15:0]      exp;
  } vec_t;

  neuron_mac #(
    .numWeight(NW), .addressWidth(AW), .dataWidth(DW), .fracBits(FB)
  ) dut (
    .clk(clk), .rst_n(rst_n), .in_data(in_data), .in_valid(in_valid),
    .in_ready(in_ready), .bias(bias), .ren(ren), .radd(radd), .wout(wout),
    .out_data(out_data), .out_valid(out_valid), .dbg_state(dbg_state)
  );

  // clock / weight memory
  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (ren) wout <= mem[radd];
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, required finish");
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, required 0x%0h", name, got, exp);
    end
  endtask

  // Reference: plain integer arithmetic with clamping and floor division.
  function automatic longint clamp(input longint v, input longint lo, input longint hi);
    if (v > hi) return hi;
    if (v < lo) return lo;
    return v;
  endfunction

  function automatic logic [15:0] ref_model(input logic [2:0][15:0] w, input logic [2:0][15:0] x,
                                            input logic [15:0] b);
    longint acc, t, q, lim;
    lim = longint'(1) << 31;
    acc = 0;
    for (int i = 0; i < NW; i++) begin
      acc = clamp(acc + longint'($signed(w[i])) * longint'($signed(x[i])), -lim, lim - 1);
    end
    t = clamp(acc + longint'($signed(b)) * 256, -lim, lim - 1);
    q = (t - (((t % 256) + 256) % 256)) / 256;
    q = clamp(q, -32768, 32767);
    return q[15:0];
  endfunction

  task automatic run_vector(input logic [2:0][15:0] w, input logic [2:0][15:0] x,
                            input logic [15:0] b, input int gap, input logic [15:0] exp,
                            input string tag);
    int seen;
    int low_cnt;
    for (int i = 0; i < NW; i++) mem[i] = w[i];
    bias = b;
    exp_q.push_back(exp);
    for (int k = 0; k < NW; k++) begin
      if (k > 0) begin
        for (int g = 0; g < gap; g++) begin
          @(negedge clk);
          in_valid = 1'b0;
          #1;
          check({tag, " ren_idle"}, {31'd0, ren}, 32'd0);
        end
      end
      @(negedge clk);
      in_valid = 1'b1;
      in_data = x[k];
      #1;
      check({tag, " ready"}, {31'd0, in_ready}, 32'd1);
      check({tag, " ren"}, {31'd0, ren}, 32'd1);
      check({tag, " radd"}, {30'd0, radd}, k);
    end
    seen = 0;
    low_cnt = 0;
    for (int n = 1; n <= 8; n++) begin
      @(negedge clk);
      in_valid = 1'b0;
      #1;
      if (!in_ready) low_cnt++;
      if (out_valid && seen == 0) begin
        seen = n;
        check({tag, " out_data"}, {16'd0, out_data}, {16'd0, exp_q.pop_front()});
      end
    end
    if (seen == 0) void'(exp_q.pop_front());
    check({tag, " latency"}, seen, 32'd4);
    check({tag, " ready_low"}, low_cnt, 32'd3);
    check({tag, " held"}, {16'd0, out_data}, {16'd0, exp});
  endtask

  vec_t tbl[6];

  initial begin
    logic [2:0][15:0] w, x;
    logic [2:0][15:0] xs[2];
    logic [15:0] b;
    int idx, outs, low_cnt;

    tbl[0] = '{"basic", {16'hFF80, 16'h0200, 16'h0100}, {16'h0200, 16'h0080, 16'h0100}, 16'h0040, 0, 16'h0140};
    tbl[1] = '{"gaps",  {16'hFF80, 16'h0200, 16'h0100}, {16'h0200, 16'h0080, 16'h0100}, 16'h0040, 2, 16'h0140};
    tbl[2] = '{"satp",  {16'h7FFF, 16'h7FFF, 16'h7FFF}, {16'h7FFF, 16'h7FFF, 16'h7FFF}, 16'h7FFF, 0, 16'h7FFF};
    tbl[3] = '{"satn",  {16'h8000, 16'h8000, 16'h8000}, {16'h7FFF, 16'h7FFF, 16'h7FFF}, 16'h0000, 1, 16'h8000};
    tbl[4] = '{"trunc", {16'h0000, 16'h0000, 16'h0001}, {16'h0000, 16'h0000, 16'h0001}, 16'hFFFF, 0, 16'hFFFF};
    tbl[5] = '{"bias",  {16'h0000, 16'h0000, 16'h0000}, {16'h0000, 16'h0000, 16'h0000}, 16'h0123, 0, 16'h0123};
    for (int i = 0; i < 4; i++) mem[i] = '0;

    // reset state
    repeat (3) @(negedge clk);
    #1;
    check("rst in_ready", {31'd0, in_ready}, 32'd1);
    check("rst ren", {31'd0, ren}, 32'd0);
    check("rst radd", {30'd0, radd}, 32'd0);
    check("rst out_data", {16'd0, out_data}, 32'd0);
    check("rst out_valid", {31'd0, out_valid}, 32'd0);
    check("rst state", {30'd0, dbg_state}, {30'd0, ACCUM});
    @(negedge clk);
    rst_n = 1'b1;

    // table-driven directed vectors
    for (int i = 0; i < 6; i++) begin
      run_vector(tbl[i].w, tbl[i].x, tbl[i].b, tbl[i].gap, tbl[i].exp, tbl[i].name);
    end

    // randomized vectors against the reference model
    for (int r = 0; r < 12; r++) begin
      for (int i = 0; i < NW; i++) begin
        if (r % 3 == 0) begin
          w[i] = 16'($urandom_range(0, 16'hFFFF));
          x[i] = 16'($urandom_range(0, 16'hFFFF));
        end else begin
          w[i] = 16'($urandom_range(0, 1024) - 512);
          x[i] = 16'($urandom_range(0, 1024) - 512);
        end
      end
      b = 16'($urandom_range(0, 16'hFFFF));
      run_vector(w, x, b, $urandom_range(0, 2), ref_model(w, x, b), "rand");
    end

    // back-to-back vectors with in_valid held high
    for (int i = 0; i < NW; i++) begin
      w[i] = 16'($urandom_range(0, 1024) - 512);
      mem[i] = w[i];
    end
    b = 16'($urandom_range(0, 512));
    bias = b;
    for (int v = 0; v < 2; v++) begin
      for (int i = 0; i < NW; i++) xs[v][i] = 16'($urandom_range(0, 1024) - 512);
      exp_q.push_back(ref_model(w, xs[v], b));
    end
    idx = 0;
    outs = 0;
    low_cnt = 0;
    for (int cyc = 0; cyc < 40 && outs < 2; cyc++) begin
      @(negedge clk);
      if (idx < 2 * NW) begin
        in_valid = 1'b1;
        in_data = xs[idx / NW][idx % NW];
        if (in_ready) idx++;
      end else begin
        in_valid = 1'b0;
      end
      #1;
      if (!in_ready) low_cnt++;
      if (out_valid) begin
        outs++;
        if (exp_q.size() > 0) check("b2b out_data", {16'd0, out_data}, {16'd0, exp_q.pop_front()});
      end
    end
    in_valid = 1'b0;
    check("b2b outputs", outs, 32'd2);
    check("b2b ready_low", low_cnt, 32'd6);
    exp_q.delete();

    // mid-vector asynchronous reset
    run_vector(tbl[0].w, tbl[0].x, tbl[0].b, 0, 16'h0140, "pre_rst");
    for (int k = 0; k < 2; k++) begin
      @(negedge clk);
      in_valid = 1'b1;
      in_data = tbl[0].x[k];
    end
    @(negedge clk);
    in_valid = 1'b0;
    #2;
    rst_n = 1'b0;
    #1;
    check("mrst out_data", {16'd0, out_data}, 32'd0);
    check("mrst out_valid", {31'd0, out_valid}, 32'd0);
    check("mrst radd", {30'd0, radd}, 32'd0);
    check("mrst in_ready", {31'd0, in_ready}, 32'd1);
    check("mrst ren", {31'd0, ren}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    run_vector(tbl[0].w, tbl[0].x, tbl[0].b, 0, 16'h0140, "post_rst");

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
